// File: rtl/vx_csr_fpu_regs_pkg.sv
// Shared definitions for the FPU-side CSR store: CSR addresses, access ops,
// field widths, the fflags layout and the CSR read-modify-write helper.
package vx_csr_fpu_regs_pkg;

   localparam int unsigned FFLAGS_BITS   = 5;
   localparam int unsigned INST_FRM_BITS = 3;
   localparam int unsigned FCSR_BITS     = FFLAGS_BITS + INST_FRM_BITS;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   typedef enum logic [1:0] {
      CsrOpRead  = 2'd0,
      CsrOpWrite = 2'd1,
      CsrOpSet   = 2'd2,
      CsrOpClear = 2'd3
   } csr_op_e;

   // Exception flag bit order, MSB first.
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   // New CSR view value produced by a csrrw/csrrs/csrrc style access.
   function automatic logic [FCSR_BITS-1:0] csr_alu(input csr_op_e op,
                                                   input logic [FCSR_BITS-1:0] old_val,
                                                   input logic [FCSR_BITS-1:0] operand);
      logic [FCSR_BITS-1:0] result;
      result = old_val;
      case (op)
         CsrOpWrite: result = operand;
         CsrOpSet:   result = old_val | operand;
         CsrOpClear: result = old_val & ~operand;
         default:    result = old_val;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/vx_csr_fpu_regs_bank.sv
// Per-warp {frm, fflags} register array. One CSR write port with independent
// field enables, merged with the FPU sticky-flag accumulate port, plus two
// asynchronous read ports (CSR side and FPU rounding-mode side).
module vx_csr_fpu_regs_bank
   import vx_csr_fpu_regs_pkg::*;
#(
   parameter int NUM_WARPS = 8,
   parameter int NW_BITS   = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     csr_wr_en,
   input  logic [NW_BITS-1:0]       csr_wr_wid,
   input  logic                     csr_wr_fflags_en,
   input  logic                     csr_wr_frm_en,
   input  logic [FCSR_BITS-1:0]     csr_wr_data,
   input  logic                     fpu_wr_en,
   input  logic [NW_BITS-1:0]       fpu_wr_wid,
   input  logic [FFLAGS_BITS-1:0]   fpu_wr_fflags,
   input  logic [NW_BITS-1:0]       csr_rd_wid,
   output logic [FCSR_BITS-1:0]     csr_rd_data,
   input  logic [NW_BITS-1:0]       fpu_rd_wid,
   output logic [INST_FRM_BITS-1:0] fpu_rd_frm
);

   // Each entry is {frm[2:0], fflags[4:0]}, i.e. the fcsr layout.
   logic [FCSR_BITS-1:0] regs_q [NUM_WARPS];
   logic [FCSR_BITS-1:0] regs_d [NUM_WARPS];

   // Next state: CSR field writes first, then FPU flags OR-ed on top so they are never lost.
   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         regs_d[w] = regs_q[w];
         if (csr_wr_en && (csr_wr_wid == NW_BITS'(w))) begin
            if (csr_wr_fflags_en) begin
               regs_d[w][FFLAGS_BITS-1:0] = csr_wr_data[FFLAGS_BITS-1:0];
            end
            if (csr_wr_frm_en) begin
               regs_d[w][FCSR_BITS-1:FFLAGS_BITS] = csr_wr_data[FCSR_BITS-1:FFLAGS_BITS];
            end
         end
         if (fpu_wr_en && (fpu_wr_wid == NW_BITS'(w))) begin
            regs_d[w][FFLAGS_BITS-1:0] = regs_d[w][FFLAGS_BITS-1:0] | fpu_wr_fflags;
         end
      end
   end

   // State array: flags cleared and rounding mode back to RNE on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            regs_q[w] <= '0;
         end
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            regs_q[w] <= regs_d[w];
         end
      end
   end

   assign csr_rd_data = regs_q[csr_rd_wid];
   assign fpu_rd_frm  = regs_q[fpu_rd_wid][FCSR_BITS-1:FFLAGS_BITS];

endmodule

// File: rtl/vx_csr_fpu_regs.sv
// Floating-point CSR slave of the FPU-to-CSR channel. Holds per-warp fflags
// and frm, accumulates FPU exception flags, feeds the rounding mode to the
// FPU and services fflags/frm/fcsr accesses with a one-entry response slot.
// Optional feature macro: CSR_FPU_FRM_BYPASS_EN forwards an accepted frm
// update to fpu_rd_frm in the same cycle; without it the FPU sees the new
// mode one cycle after acceptance.
module vx_csr_fpu_regs
   import vx_csr_fpu_regs_pkg::*;
#(
   parameter int NUM_WARPS = 8,
   parameter int XLEN      = 32,
   parameter int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fpu_wr_en,
   input  logic [NW_BITS-1:0]       fpu_wr_wid,
   input  logic [FFLAGS_BITS-1:0]   fpu_wr_fflags,
   input  logic [NW_BITS-1:0]       fpu_rd_wid,
   output logic [INST_FRM_BITS-1:0] fpu_rd_frm,
   input  logic                     csr_req_valid,
   output logic                     csr_req_ready,
   input  logic [NW_BITS-1:0]       csr_req_wid,
   input  logic [11:0]              csr_req_addr,
   input  logic [1:0]               csr_req_op,
   input  logic [XLEN-1:0]          csr_req_data,
   output logic                     csr_rsp_valid,
   input  logic                     csr_rsp_ready,
   output logic [NW_BITS-1:0]       csr_rsp_wid,
   output logic [XLEN-1:0]          csr_rsp_data,
   output logic                     csr_rsp_err
);

   csr_op_e                  req_op;
   logic                     req_accept;
   logic                     addr_fflags;
   logic                     addr_frm;
   logic                     addr_fcsr;
   logic                     addr_ok;
   logic [FCSR_BITS-1:0]     cur_fcsr;
   logic [FCSR_BITS-1:0]     old_view;
   logic [FCSR_BITS-1:0]     new_view;
   logic [FCSR_BITS-1:0]     wr_data;
   logic [INST_FRM_BITS-1:0] new_frm;
   logic                     wr_en;
   logic                     wr_fflags_en;
   logic                     wr_frm_en;
   logic [INST_FRM_BITS-1:0] bank_fpu_frm;

   logic                     rsp_valid_q;
   logic [NW_BITS-1:0]       rsp_wid_q;
   logic [XLEN-1:0]          rsp_data_q;
   logic                     rsp_err_q;

   // Operand bits above the widest view never reach any field.
   logic unused_req_data;
   assign unused_req_data = ^csr_req_data[XLEN-1:FCSR_BITS];

   assign req_op        = csr_op_e'(csr_req_op);
   assign csr_req_ready = !rsp_valid_q || csr_rsp_ready;
   assign req_accept    = csr_req_valid && csr_req_ready;

   // Address decode and the old/new value of the addressed view.
   always_comb begin
      addr_fflags = (csr_req_addr == CSR_FFLAGS);
      addr_frm    = (csr_req_addr == CSR_FRM);
      addr_fcsr   = (csr_req_addr == CSR_FCSR);
      addr_ok     = addr_fflags || addr_frm || addr_fcsr;

      old_view = '0;
      if (addr_fflags) begin
         old_view = {{INST_FRM_BITS{1'b0}}, cur_fcsr[FFLAGS_BITS-1:0]};
      end else if (addr_frm) begin
         old_view = {{FFLAGS_BITS{1'b0}}, cur_fcsr[FCSR_BITS-1:FFLAGS_BITS]};
      end else if (addr_fcsr) begin
         old_view = cur_fcsr;
      end

      new_view = csr_alu(req_op, old_view, csr_req_data[FCSR_BITS-1:0]);
   end

   // Map the new view back onto the {frm, fflags} storage layout.
   always_comb begin
      wr_en        = req_accept && addr_ok && (req_op != CsrOpRead);
      wr_fflags_en = addr_fflags || addr_fcsr;
      wr_frm_en    = addr_frm || addr_fcsr;
      if (addr_frm) begin
         new_frm = new_view[INST_FRM_BITS-1:0];
         wr_data = {new_frm, cur_fcsr[FFLAGS_BITS-1:0]};
      end else begin
         new_frm = new_view[FCSR_BITS-1:FFLAGS_BITS];
         wr_data = new_view;
      end
   end

   vx_csr_fpu_regs_bank #(
      .NUM_WARPS (NUM_WARPS),
      .NW_BITS   (NW_BITS)
   ) u_bank (
      .clk              (clk),
      .reset            (reset),
      .csr_wr_en        (wr_en),
      .csr_wr_wid       (csr_req_wid),
      .csr_wr_fflags_en (wr_fflags_en),
      .csr_wr_frm_en    (wr_frm_en),
      .csr_wr_data      (wr_data),
      .fpu_wr_en        (fpu_wr_en),
      .fpu_wr_wid       (fpu_wr_wid),
      .fpu_wr_fflags    (fpu_wr_fflags),
      .csr_rd_wid       (csr_req_wid),
      .csr_rd_data      (cur_fcsr),
      .fpu_rd_wid       (fpu_rd_wid),
      .fpu_rd_frm       (bank_fpu_frm)
   );

`ifdef CSR_FPU_FRM_BYPASS_EN
   // Forward a frm update being accepted this cycle to the FPU read port.
   always_comb begin
      fpu_rd_frm = bank_fpu_frm;
      if (wr_en && wr_frm_en && (csr_req_wid == fpu_rd_wid)) begin
         fpu_rd_frm = new_frm;
      end
   end
`else
   // FPU sees registered state only; keeps req->frm free of combinational paths.
   always_comb begin
      fpu_rd_frm = bank_fpu_frm;
   end
`endif

   // Response slot: capture the pre-update view on accept, hold until consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_wid_q   <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else if (req_accept) begin
         rsp_valid_q <= 1'b1;
         rsp_wid_q   <= csr_req_wid;
         rsp_data_q  <= addr_ok ? {{(XLEN-FCSR_BITS){1'b0}}, old_view} : '0;
         rsp_err_q   <= !addr_ok;
      end else if (csr_rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign csr_rsp_valid = rsp_valid_q;
   assign csr_rsp_wid   = rsp_wid_q;
   assign csr_rsp_data  = rsp_data_q;
   assign csr_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_vx_csr_fpu_regs.sv
// Self-checking bench for vx_csr_fpu_regs: table of request vectors with
// expected responses pushed to a scoreboard queue, plus hand-written stall,
// frm-forwarding and mid-transaction reset sequences.
`timescale 1ns/1ps
module tb_vx_csr_fpu_regs;

   localparam int NUM_WARPS = 8;
   localparam int XLEN      = 32;
   localparam int NW_BITS   = 3;
`ifdef CSR_FPU_FRM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                clk;
   logic                reset;
   logic                fpu_wr_en;
   logic [NW_BITS-1:0]  fpu_wr_wid;
   logic [4:0]          fpu_wr_fflags;
   logic [NW_BITS-1:0]  fpu_rd_wid;
   logic [2:0]          fpu_rd_frm;
   logic                csr_req_valid;
   logic                csr_req_ready;
   logic [NW_BITS-1:0]  csr_req_wid;
   logic [11:0]         csr_req_addr;
   logic [1:0]          csr_req_op;
   logic [XLEN-1:0]     csr_req_data;
   logic                csr_rsp_valid;
   logic                csr_rsp_ready;
   logic [NW_BITS-1:0]  csr_rsp_wid;
   logic [XLEN-1:0]     csr_rsp_data;
   logic                csr_rsp_err;

   vx_csr_fpu_regs #(
      .NUM_WARPS (NUM_WARPS),
      .XLEN      (XLEN)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fpu_wr_en     (fpu_wr_en),
      .fpu_wr_wid    (fpu_wr_wid),
      .fpu_wr_fflags (fpu_wr_fflags),
      .fpu_rd_wid    (fpu_rd_wid),
      .fpu_rd_frm    (fpu_rd_frm),
      .csr_req_valid (csr_req_valid),
      .csr_req_ready (csr_req_ready),
      .csr_req_wid   (csr_req_wid),
      .csr_req_addr  (csr_req_addr),
      .csr_req_op    (csr_req_op),
      .csr_req_data  (csr_req_data),
      .csr_rsp_valid (csr_rsp_valid),
      .csr_rsp_ready (csr_rsp_ready),
      .csr_rsp_wid   (csr_rsp_wid),
      .csr_rsp_data  (csr_rsp_data),
      .csr_rsp_err   (csr_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NW_BITS-1:0] wid;
      logic [XLEN-1:0]    data;
      logic               err;
   } rsp_t;

   typedef struct {
      logic               fpu_en;
      logic [NW_BITS-1:0] fpu_wid;
      logic [4:0]         fpu_flags;
      logic [NW_BITS-1:0] wid;
      logic [11:0]        addr;
      logic [1:0]         op;
      logic [XLEN-1:0]    data;
      logic [XLEN-1:0]    exp_data;
      logic               exp_err;
   } vec_t;

   rsp_t exp_q[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic fe, input int fw, input logic [4:0] ff, input int w,
                          input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee);
      vec_t v;
      v.fpu_en = fe; v.fpu_wid = NW_BITS'(fw); v.fpu_flags = ff;
      v.wid = NW_BITS'(w); v.addr = a; v.op = op; v.data = d;
      v.exp_data = ed; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input logic [NW_BITS-1:0] w, input logic [31:0] d, input logic e);
      rsp_t r;
      r.wid = w; r.data = d; r.err = e;
      exp_q.push_back(r);
   endtask

   // Drives one request (and an optional same-cycle FPU report) until accepted.
   task automatic issue(input vec_t v);
      int n;
      n = 0;
      fpu_wr_en     = v.fpu_en;
      fpu_wr_wid    = v.fpu_wid;
      fpu_wr_fflags = v.fpu_flags;
      csr_req_valid = 1'b1;
      csr_req_wid   = v.wid;
      csr_req_addr  = v.addr;
      csr_req_op    = v.op;
      csr_req_data  = v.data;
      #1;
      while (!csr_req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!csr_req_ready) begin
         n_checks++;
         n_fails++;
         $display("FAIL accept_timeout: req_ready=%0b required 1", csr_req_ready);
      end else begin
         push_exp(v.wid, v.exp_data, v.exp_err);
      end
      @(posedge clk); #1;
      fpu_wr_en     = 1'b0;
      csr_req_valid = 1'b0;
   endtask

   // Scoreboard: every consumed response is compared against the oldest expectation.
   always @(negedge clk) begin
      rsp_t e;
      if (!reset && csr_rsp_valid && csr_rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_rsp: wid=%0d data=0x%0h err=%0b, none required",
                     csr_rsp_wid, csr_rsp_data, csr_rsp_err);
         end else begin
            e = exp_q.pop_front();
            check("rsp {wid,err,data}", {csr_rsp_wid, csr_rsp_err, csr_rsp_data},
                  {e.wid, e.err, e.data});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] exp_frm [NUM_WARPS];
      vec_t v;

      reset = 1'b1;
      fpu_wr_en = 1'b0; fpu_wr_wid = '0; fpu_wr_fflags = '0; fpu_rd_wid = '0;
      csr_req_valid = 1'b0; csr_req_wid = '0; csr_req_addr = '0; csr_req_op = '0;
      csr_req_data = '0; csr_rsp_ready = 1'b1;

      // Vector table: fpu_en, fpu_wid, fpu_flags, wid, addr, op, data, exp_data, exp_err
      add_vec(0, 0, 5'h00, 0, 12'h003, 2'd0, 32'h0,        32'h00, 0); // reset fcsr
      add_vec(1, 2, 5'h01, 2, 12'h001, 2'd0, 32'h0,        32'h00, 0); // pre-edge view
      add_vec(1, 2, 5'h10, 2, 12'h001, 2'd0, 32'h0,        32'h01, 0);
      add_vec(0, 0, 5'h00, 2, 12'h001, 2'd0, 32'h0,        32'h11, 0); // sticky OR
      add_vec(0, 0, 5'h00, 1, 12'h001, 2'd0, 32'h0,        32'h00, 0);
      add_vec(1, 3, 5'h01, 3, 12'h001, 2'd1, 32'h4,        32'h00, 0); // same-edge merge
      add_vec(0, 0, 5'h00, 3, 12'h001, 2'd0, 32'h0,        32'h05, 0);
      add_vec(0, 0, 5'h00, 1, 12'h002, 2'd1, 32'h3,        32'h00, 0); // RW frm
      add_vec(0, 0, 5'h00, 1, 12'h003, 2'd2, 32'hE0,       32'h60, 0); // RS fcsr
      add_vec(0, 0, 5'h00, 1, 12'h003, 2'd3, 32'h40,       32'hE0, 0); // RC fcsr -> frm 5
      add_vec(0, 0, 5'h00, 1, 12'h002, 2'd0, 32'h0,        32'h05, 0);
      add_vec(0, 0, 5'h00, 4, 12'h002, 2'd2, 32'hFFFFFFFE, 32'h00, 0); // upper bits ignored
      add_vec(0, 0, 5'h00, 4, 12'h003, 2'd0, 32'h0,        32'hC0, 0);
      add_vec(0, 0, 5'h00, 3, 12'h001, 2'd3, 32'hFFFFFFFB, 32'h05, 0); // RC fflags
      add_vec(1, 5, 5'h1F, 3, 12'h003, 2'd1, 32'h123,      32'h04, 0); // different warps
      add_vec(0, 0, 5'h00, 3, 12'h003, 2'd0, 32'h0,        32'h23, 0);
      add_vec(0, 0, 5'h00, 5, 12'h001, 2'd0, 32'h0,        32'h1F, 0);
      add_vec(0, 0, 5'h00, 0, 12'h300, 2'd1, 32'hFF,       32'h00, 1); // bad address
      add_vec(0, 0, 5'h00, 0, 12'h003, 2'd0, 32'h0,        32'h00, 0);
      add_vec(0, 0, 5'h00, 0, 12'h000, 2'd0, 32'h0,        32'h00, 1);
      add_vec(0, 0, 5'h00, 0, 12'h004, 2'd2, 32'hFF,       32'h00, 1);
      add_vec(0, 0, 5'h00, 5, 12'h001, 2'd0, 32'h1,        32'h1F, 0); // op 0 never writes
      add_vec(0, 0, 5'h00, 5, 12'h001, 2'd0, 32'h0,        32'h1F, 0);

      @(posedge clk); #1;
      check("reset rsp_valid", csr_rsp_valid, 0);
      check("reset rsp_wid", csr_rsp_wid, 0);
      check("reset rsp_data", csr_rsp_data, 0);
      check("reset rsp_err", csr_rsp_err, 0);
      check("reset req_ready", csr_req_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;

      for (int w = 0; w < NUM_WARPS; w++) begin
         fpu_rd_wid = NW_BITS'(w);
         #1;
         check($sformatf("reset fpu_rd_frm w%0d", w), fpu_rd_frm, 0);
      end
      @(posedge clk); #1;

      foreach (vecs[i]) issue(vecs[i]);
      @(posedge clk); #1;

      exp_frm = '{3'd0, 3'd5, 3'd0, 3'd1, 3'd6, 3'd0, 3'd0, 3'd0};
      for (int w = 0; w < NUM_WARPS; w++) begin
         fpu_rd_wid = NW_BITS'(w);
         #1;
         check($sformatf("fpu_rd_frm w%0d", w), fpu_rd_frm, exp_frm[w]);
      end

      // Backpressure: response A held while request B waits.
      csr_rsp_ready = 1'b0;
      csr_req_valid = 1'b1; csr_req_wid = 3'd4; csr_req_addr = 12'h003;
      csr_req_op = 2'd0; csr_req_data = '0;
      #1;
      check("stall first accept ready", csr_req_ready, 1);
      push_exp(3'd4, 32'hC0, 1'b0);
      @(posedge clk); #1;
      csr_req_wid = 3'd1; csr_req_addr = 12'h002;
      for (int c = 0; c < 3; c++) begin
         check("stall req_ready", csr_req_ready, 0);
         check("stall rsp_valid", csr_rsp_valid, 1);
         check("stall rsp_wid", csr_rsp_wid, 4);
         check("stall rsp_data", csr_rsp_data, 32'hC0);
         @(posedge clk); #1;
      end
      csr_rsp_ready = 1'b1;
      push_exp(3'd1, 32'h5, 1'b0);
      @(posedge clk); #1;
      csr_req_valid = 1'b0;
      @(posedge clk); #1;

      // frm write seen by the FPU: same cycle only with forwarding enabled.
      fpu_rd_wid = 3'd0;
      csr_req_valid = 1'b1; csr_req_wid = 3'd0; csr_req_addr = 12'h002;
      csr_req_op = 2'd1; csr_req_data = 32'h2;
      #1;
      check("frm same cycle", fpu_rd_frm, BYPASS ? 3'd2 : 3'd0);
      push_exp(3'd0, 32'h0, 1'b0);
      @(posedge clk); #1;
      check("frm next cycle", fpu_rd_frm, 2);
      csr_req_wid = 3'd6; csr_req_data = 32'h7;
      #1;
      check("frm other warp no forward", fpu_rd_frm, 2);
      push_exp(3'd6, 32'h0, 1'b0);
      @(posedge clk); #1;
      csr_req_valid = 1'b0;
      @(posedge clk); #1;

      // Reset with a response pending drops it and clears all state.
      csr_rsp_ready = 1'b0;
      v.fpu_en = 0; v.fpu_wid = 0; v.fpu_flags = 0;
      csr_req_valid = 1'b1; csr_req_wid = 3'd1; csr_req_addr = 12'h003;
      csr_req_op = 2'd0; csr_req_data = '0;
      @(posedge clk); #1;
      csr_req_valid = 1'b0;
      check("pending rsp before reset", {csr_rsp_valid, csr_rsp_data}, {1'b1, 32'hA0});
      reset = 1'b1;
      #1;
      check("reset drops rsp_valid", csr_rsp_valid, 0);
      check("reset clears rsp_data", csr_rsp_data, 0);
      check("reset clears frm w0", fpu_rd_frm, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      csr_rsp_ready = 1'b1;
      v.wid = 3'd1; v.addr = 12'h003; v.op = 2'd0; v.data = 0; v.exp_data = 0; v.exp_err = 0;
      issue(v);
      v.wid = 3'd5; v.addr = 12'h001;
      issue(v);
      @(posedge clk); #1;
      @(posedge clk); #1;

      check("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
